ram_access_ctrl: RTL and testbench
==================================

// Module: ram_access_ctrl
// PURPOSE
//  Initiator side of the 16x8 RAM port (CLK, R_W, ADDR[3:0], DATA_IN[7:0], DATA_OUT[7:0]).
//  Accepts single or burst read/write commands on a valid/ready interface and sequences the RAM pins.
//  Returns read data on a valid/ready response interface with a last-beat marker.
//  Sits between a test/CPU-side master and the RAM array.
// PARAMETERS
//  AW      4  RAM address width; address wraps modulo 2**AW
//  DW      8  RAM data width
//  RD_LAT  1  cycles from RAM_ADDR/R_W=0 registered to RAM_DATA_OUT valid (1..3)
// PORTS
//  CLK          in   1   clock, all logic on rising edge
//  RST          in   1   synchronous, active-high reset
//  CMD_VALID    in   1   command present
//  CMD_READY    out  1   controller can accept command (high only in IDLE)
//  CMD_WR       in   1   1 = write burst, 0 = read burst
//  CMD_ADDR     in   AW  start address
//  CMD_LEN      in   AW  beats-1 (0 = single access, 15 = full array)
//  CMD_DATA     in   DW  write seed value
//  CMD_INC      in   1   write pattern: 1 = seed+beat index, 0 = constant seed
//  RAM_R_W      out  1   1 = write this cycle, 0 = read
//  RAM_ADDR     out  AW  RAM address
//  RAM_DATA_IN  out  DW  RAM write data
//  RAM_DATA_OUT in   DW  RAM read data
//  RSP_VALID    out  1   read beat available
//  RSP_READY    in   1   master accepts read beat
//  RSP_DATA     out  DW  read data
//  RSP_LAST     out  1   final beat of burst, qualified by RSP_VALID
//  BUSY         out  1   high whenever state != IDLE
// BEHAVIOUR
//  Reset: state=IDLE; RAM_R_W=0, RAM_ADDR=0, RAM_DATA_IN=0, RSP_VALID=0, RSP_DATA=0, RSP_LAST=0, BUSY=0.
//  CMD_READY = (state==IDLE) & !RST; command captured on CMD_VALID&CMD_READY edge.
//  All RAM_* and RSP_* outputs are registered.
//  States: IDLE, WR_BEAT, RD_ISSUE, RD_WAIT, RD_RESP.
//  IDLE -> WR_BEAT (CMD_WR=1) or RD_ISSUE (CMD_WR=0); beat counter cleared, addr <= CMD_ADDR.
//  WR_BEAT: one write per cycle; RAM_R_W=1, RAM_ADDR=start+i, RAM_DATA_IN = CMD_INC ? seed+i : seed.
//    Sums truncated mod 2**AW (address) and mod 2**DW (data).
//    After beat i==LEN: RAM_R_W<=0 next cycle, -> IDLE. Burst of N beats holds BUSY for N cycles.
//  RD_ISSUE: RAM_R_W=0, RAM_ADDR=start+i; -> RD_WAIT.
//  RD_WAIT: counts RD_LAT cycles, then samples RAM_DATA_OUT into RSP_DATA, RSP_VALID<=1,
//    RSP_LAST<=(i==LEN); -> RD_RESP.
//  RD_RESP: hold RSP_VALID/DATA/LAST stable until RSP_READY.
//    On handshake: RSP_VALID<=0; if last -> IDLE else i++, -> RD_ISSUE.
//  Read throughput: one beat per RD_LAT+2 cycles with RSP_READY held high.
//  Wrap: CMD_ADDR=14, LEN=3 accesses 14,15,0,1.
//  Reset mid-burst: abort immediately, outputs to reset values; no further RAM writes.
//  CMD_VALID while busy is ignored (no queueing). Write bursts never assert RSP_VALID.
//  RAM_R_W is never 1 outside WR_BEAT.
// STRUCTURE
//  Package ram_ctrl_pkg: state enum (5 codes), localparams AW/DW defaults, RD_LAT max.
//  Sub-module ram_beat_gen: beat counter, wrapped address and write-pattern generator.
//  The FSM and response register live in the top.
// TESTING
//  Benches use the 16x8 RAM model with RD_LAT=1.
//  Single write then read: write A=3 D=0x5A; read A=3 LEN=0 -> one RSP 0x5A, RSP_LAST=1.
//  Incrementing fill: A=0 LEN=15 D=0x10 INC=1, then read all -> RSP_DATA 0x10..0x1F in order.
//    LAST only on the 16th beat.
//  Wrap: write A=14 LEN=3 D=0xC0 INC=1 -> RAM[14]=C0, [15]=C1, [0]=C2, [1]=C3; RAM[2] untouched.
//  Backpressure: read A=0 LEN=2 with RSP_READY low 5 cycles per beat -> VALID/DATA stable.
//    No beat lost or duplicated; no new RAM read issued while stalled.
//  Reset mid write burst: RST at beat 4 of LEN=15 -> RAM[4..15] unchanged, RAM_R_W=0 next edge.
//    CMD_READY returns high after RST deasserts.
//  Busy rejection: CMD_VALID pulse during burst -> CMD_READY=0, command not executed.
//    Next accepted command behaves normally.

Source files
------------

// File: rtl/ram_ctrl_pkg.sv
// ram_ctrl_pkg: shared state encoding and size defaults for the RAM access controller
package ram_ctrl_pkg;
  localparam int AW_DEF = 4;
  localparam int DW_DEF = 8;
  localparam int RD_LAT_MAX = 3;
  localparam int WAIT_W = $clog2(RD_LAT_MAX);
  typedef enum logic [2:0] {IDLE, WR_BEAT, RD_ISSUE, RD_WAIT, RD_RESP} state_t;
endpackage

// File: rtl/ram_beat_gen.sv
// ram_beat_gen: beat counter with wrapped address and write-pattern lookahead for the next beat
module ram_beat_gen #(
  parameter int AW = 4,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_load,
  input  logic          i_step,
  input  logic [AW-1:0] i_addr,
  input  logic [AW-1:0] i_len,
  input  logic [DW-1:0] i_seed,
  input  logic          i_inc,
  output logic [AW-1:0] o_addr,
  output logic [DW-1:0] o_data,
  output logic          o_last
);
  logic [AW-1:0] r_i, r_start, r_len;
  logic [DW-1:0] r_seed;
  logic          r_inc;
  logic [AW-1:0] w_i, w_start;
  logic [DW-1:0] w_seed;
  logic          w_inc;
  // o_addr/o_data describe the beat that becomes current after this edge
  always_comb begin
    w_start = i_load ? i_addr : r_start;
    w_seed  = i_load ? i_seed : r_seed;
    w_inc   = i_load ? i_inc : r_inc;
    w_i     = i_load ? '0 : i_step ? r_i + 1'b1 : r_i;
    o_addr  = w_start + w_i;
    o_data  = w_seed + (w_inc ? DW'(w_i) : '0);
    o_last  = r_i == r_len;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_i     <= '0;
      r_start <= '0;
      r_len   <= '0;
      r_seed  <= '0;
      r_inc   <= 1'b0;
    end else begin
      r_i <= w_i;
      if (i_load) begin
        r_start <= i_addr;
        r_len   <= i_len;
        r_seed  <= i_seed;
        r_inc   <= i_inc;
      end
    end
  end
endmodule

// File: rtl/ram_access_ctrl.sv
// ram_access_ctrl: burst read/write sequencer driving a synchronous RAM port
module ram_access_ctrl
  import ram_ctrl_pkg::*;
#(
  parameter int AW     = AW_DEF,
  parameter int DW     = DW_DEF,
  parameter int RD_LAT = 1
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          CMD_VALID,
  output logic          CMD_READY,
  input  logic          CMD_WR,
  input  logic [AW-1:0] CMD_ADDR,
  input  logic [AW-1:0] CMD_LEN,
  input  logic [DW-1:0] CMD_DATA,
  input  logic          CMD_INC,
  output logic          RAM_R_W,
  output logic [AW-1:0] RAM_ADDR,
  output logic [DW-1:0] RAM_DATA_IN,
  input  logic [DW-1:0] RAM_DATA_OUT,
  output logic          RSP_VALID,
  input  logic          RSP_READY,
  output logic [DW-1:0] RSP_DATA,
  output logic          RSP_LAST,
  output logic          BUSY
);
  localparam logic [WAIT_W-1:0] WAIT_END = WAIT_W'(RD_LAT - 1);
  state_t              r_state, w_nxt;
  logic [WAIT_W-1:0]   r_wait, w_wait;
  logic                r_ram_rw, w_rw;
  logic [AW-1:0]       r_ram_addr, w_addr, w_gaddr;
  logic [DW-1:0]       r_ram_din, w_din, w_gdata;
  logic                r_rsp_valid, w_rv;
  logic [DW-1:0]       r_rsp_data, w_rd;
  logic                r_rsp_last, w_rl;
  logic                w_load, w_step, w_last;
  ram_beat_gen #(.AW(AW), .DW(DW)) u_beat (
    .clk    (CLK),
    .rst    (RST),
    .i_load (w_load),
    .i_step (w_step),
    .i_addr (CMD_ADDR),
    .i_len  (CMD_LEN),
    .i_seed (CMD_DATA),
    .i_inc  (CMD_INC),
    .o_addr (w_gaddr),
    .o_data (w_gdata),
    .o_last (w_last)
  );
  always_comb begin
    w_nxt  = r_state;
    w_load = 1'b0;
    w_step = 1'b0;
    w_wait = r_wait;
    w_rw   = r_ram_rw;
    w_addr = r_ram_addr;
    w_din  = r_ram_din;
    w_rv   = r_rsp_valid;
    w_rd   = r_rsp_data;
    w_rl   = r_rsp_last;
    case (r_state)
      IDLE: if (CMD_VALID) begin
        w_load = 1'b1;
        w_nxt  = CMD_WR ? WR_BEAT : RD_ISSUE;
        w_rw   = CMD_WR;
        w_addr = w_gaddr;
        w_din  = CMD_WR ? w_gdata : r_ram_din;
      end
      WR_BEAT: if (w_last) begin
        w_nxt = IDLE;
        w_rw  = 1'b0;
      end else begin
        w_step = 1'b1;
        w_addr = w_gaddr;
        w_din  = w_gdata;
      end
      RD_ISSUE: begin
        w_nxt  = RD_WAIT;
        w_wait = '0;
      end
      RD_WAIT: if (r_wait == WAIT_END) begin
        w_nxt = RD_RESP;
        w_rv  = 1'b1;
        w_rd  = RAM_DATA_OUT;
        w_rl  = w_last;
      end else w_wait = r_wait + 1'b1;
      RD_RESP: if (RSP_READY) begin
        w_rv  = 1'b0;
        w_rl  = 1'b0;
        w_nxt = w_last ? IDLE : RD_ISSUE;
        if (!w_last) begin
          w_step = 1'b1;
          w_addr = w_gaddr;
        end
      end
      default: w_nxt = IDLE;
    endcase
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state     <= IDLE;
      r_wait      <= '0;
      r_ram_rw    <= 1'b0;
      r_ram_addr  <= '0;
      r_ram_din   <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
      r_rsp_last  <= 1'b0;
    end else begin
      r_state     <= w_nxt;
      r_wait      <= w_wait;
      r_ram_rw    <= w_rw;
      r_ram_addr  <= w_addr;
      r_ram_din   <= w_din;
      r_rsp_valid <= w_rv;
      r_rsp_data  <= w_rd;
      r_rsp_last  <= w_rl;
    end
  end
  assign CMD_READY   = (r_state == IDLE) & ~RST;
  assign BUSY        = r_state != IDLE;
  assign RAM_R_W     = r_ram_rw;
  assign RAM_ADDR    = r_ram_addr;
  assign RAM_DATA_IN = r_ram_din;
  assign RSP_VALID   = r_rsp_valid;
  assign RSP_DATA    = r_rsp_data;
  assign RSP_LAST    = r_rsp_last;
endmodule

// File: tb/tb_ram_access_ctrl.sv
// tb_ram_access_ctrl: vector table, corner sequences and random bursts against a memory model
module tb_ram_access_ctrl;
  logic CLK = 0, RST = 1, CMD_VALID = 0, CMD_WR = 0, CMD_INC = 0, RSP_READY = 0;
  logic [3:0] CMD_ADDR = 0, CMD_LEN = 0;
  logic [7:0] CMD_DATA = 0;
  logic CMD_READY, RAM_R_W, RSP_VALID, RSP_LAST, BUSY;
  logic [3:0] RAM_ADDR;
  logic [7:0] RAM_DATA_IN, RAM_DATA_OUT, RSP_DATA;
  logic [7:0] mem[16];
  logic [7:0] ref_mem[16];
  int checks = 0, passed = 0, cyc = 0, bad_rw = 0;
  typedef struct {
    logic wr; logic [3:0] a; logic [3:0] l; logic [7:0] d; logic inc; int stall;
    logic [7:0] e0; logic [7:0] el;
  } vec_t;
  vec_t tbl[9];
  always #5 CLK = ~CLK;
  ram_access_ctrl dut (
    .CLK(CLK), .RST(RST), .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY), .CMD_WR(CMD_WR),
    .CMD_ADDR(CMD_ADDR), .CMD_LEN(CMD_LEN), .CMD_DATA(CMD_DATA), .CMD_INC(CMD_INC),
    .RAM_R_W(RAM_R_W), .RAM_ADDR(RAM_ADDR), .RAM_DATA_IN(RAM_DATA_IN), .RAM_DATA_OUT(RAM_DATA_OUT),
    .RSP_VALID(RSP_VALID), .RSP_READY(RSP_READY), .RSP_DATA(RSP_DATA), .RSP_LAST(RSP_LAST), .BUSY(BUSY)
  );
  always @(posedge CLK) begin
    cyc <= cyc + 1;
    if (RAM_R_W) mem[RAM_ADDR] <= RAM_DATA_IN;
    else RAM_DATA_OUT <= mem[RAM_ADDR];
  end
  always @(negedge CLK) if (RAM_R_W && !BUSY) bad_rw <= bad_rw + 1;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask
  task automatic model_write(input logic [3:0] a, input logic [7:0] d, input logic inc, input int n);
    for (int i = 0; i < n; i++) ref_mem[4'(a + i)] = inc ? 8'(d + i) : d;
  endtask
  task automatic issue(input logic wr, input logic [3:0] a, input logic [3:0] l, input logic [7:0] d,
                       input logic inc, input int nm);
    int t = 0;
    @(negedge CLK);
    while (!CMD_READY && t < 50) begin @(negedge CLK); t++; end
    chk("cmd_ready", CMD_READY, 1);
    CMD_VALID = 1; CMD_WR = wr; CMD_ADDR = a; CMD_LEN = l; CMD_DATA = d; CMD_INC = inc;
    @(posedge CLK);
    #1 CMD_VALID = 0;
    model_write(a, d, inc, nm);
  endtask
  task automatic finish_write(input int exp_n);
    int n = 0, w = 0, rv = 0;
    @(negedge CLK);
    while (BUSY && n < 100) begin
      n++;
      if (RAM_R_W) w++;
      if (RSP_VALID) rv++;
      @(negedge CLK);
    end
    chk("wr_busy_cycles", n, exp_n);
    chk("wr_beats", w, exp_n);
    chk("wr_no_rsp", rv, 0);
    chk("wr_rw_low", RAM_R_W, 0);
  endtask
  task automatic read_beats(input logic [3:0] a, input logic [3:0] l, input int stall,
                            output logic [7:0] d0, output logic [7:0] dl);
    int t, last_cyc;
    logic [7:0] hd;
    logic [3:0] ha;
    last_cyc = 0;
    d0 = 0;
    dl = 0;
    RSP_READY = (stall == 0);
    @(negedge CLK);
    for (int b = 0; b <= int'(l); b++) begin
      t = 0;
      while (!RSP_VALID && t < 50) begin @(negedge CLK); t++; end
      chk("rsp_valid", RSP_VALID, 1);
      if (b > 0 && stall == 0) chk("rd_gap", cyc - last_cyc, 3);
      last_cyc = cyc;
      chk("rsp_data", RSP_DATA, ref_mem[4'(a + b)]);
      chk("rsp_last", RSP_LAST, b == int'(l));
      if (b == 0) d0 = RSP_DATA;
      dl = RSP_DATA;
      if (stall > 0) begin
        hd = RSP_DATA;
        ha = RAM_ADDR;
        repeat (stall) begin
          @(negedge CLK);
          chk("stall_hold", {RSP_VALID, RSP_LAST, RSP_DATA, RAM_ADDR, RAM_R_W},
              {1'b1, b == int'(l), hd, ha, 1'b0});
        end
        RSP_READY = 1;
        @(negedge CLK);
        RSP_READY = 0;
      end else @(negedge CLK);
    end
    RSP_READY = 0;
    chk("rd_done_idle", {BUSY, RSP_VALID}, 0);
  endtask
  task automatic mem_cmp();
    int mm = 0;
    for (int i = 0; i < 16; i++) if (mem[i] !== ref_mem[i]) mm++;
    chk("mem_match", mm, 0);
  endtask
  initial begin
    logic [7:0] d0, dl;
    logic wr, inc;
    logic [3:0] a, l;
    logic [7:0] d;
    int st, t;
    tbl[0] = '{1, 3, 0, 8'h5A, 0, 0, 0, 0};
    tbl[1] = '{0, 3, 0, 0, 0, 0, 8'h5A, 8'h5A};
    tbl[2] = '{1, 0, 15, 8'h10, 1, 0, 0, 0};
    tbl[3] = '{0, 0, 15, 0, 0, 0, 8'h10, 8'h1F};
    tbl[4] = '{1, 14, 3, 8'hC0, 1, 0, 0, 0};
    tbl[5] = '{0, 13, 5, 0, 0, 0, 8'h1D, 8'h12};
    tbl[6] = '{0, 0, 2, 0, 0, 5, 8'hC2, 8'h12};
    tbl[7] = '{1, 5, 2, 8'h77, 0, 0, 0, 0};
    tbl[8] = '{0, 4, 4, 0, 0, 0, 8'h14, 8'h18};
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    chk("rst_outputs", {RAM_R_W, RAM_ADDR, RAM_DATA_IN, RSP_VALID, RSP_DATA, RSP_LAST, BUSY}, 0);
    chk("rst_cmd_ready", CMD_READY, 0);
    RST = 0;
    #1 chk("post_rst_ready", CMD_READY, 1);
    foreach (tbl[i]) begin
      issue(tbl[i].wr, tbl[i].a, tbl[i].l, tbl[i].d, tbl[i].inc, tbl[i].wr ? int'(tbl[i].l) + 1 : 0);
      if (tbl[i].wr) finish_write(int'(tbl[i].l) + 1);
      else begin
        read_beats(tbl[i].a, tbl[i].l, tbl[i].stall, d0, dl);
        chk("tbl_first", d0, tbl[i].e0);
        chk("tbl_last", dl, tbl[i].el);
      end
    end
    mem_cmp();
    issue(1, 8, 5, 8'h60, 0, 6);
    @(negedge CLK);
    CMD_VALID = 1; CMD_WR = 1; CMD_ADDR = 2; CMD_LEN = 0; CMD_DATA = 8'hEE;
    chk("busy_ready_low", CMD_READY, 0);
    @(posedge CLK);
    #1 CMD_VALID = 0;
    finish_write(5);
    issue(0, 1, 2, 0, 0, 0);
    read_beats(1, 2, 0, d0, dl);
    chk("after_reject_first", d0, 8'hC3);
    mem_cmp();
    issue(1, 0, 15, 8'hA0, 1, 4);
    t = 0;
    @(negedge CLK);
    while (!(RAM_R_W && RAM_ADDR == 3) && t < 50) begin @(negedge CLK); t++; end
    chk("reached_beat3", {RAM_R_W, RAM_ADDR}, {1'b1, 4'd3});
    RST = 1;
    @(negedge CLK);
    chk("midrst_outputs", {RAM_R_W, RAM_ADDR, RAM_DATA_IN, RSP_VALID, BUSY, CMD_READY}, 0);
    RST = 0;
    #1 chk("midrst_ready", CMD_READY, 1);
    mem_cmp();
    for (int k = 0; k < 24; k++) begin
      wr = 1'($urandom_range(0, 1));
      a = 4'($urandom);
      l = 4'($urandom_range(0, 7));
      d = 8'($urandom);
      inc = 1'($urandom_range(0, 1));
      st = $urandom_range(0, 2);
      issue(wr, a, l, d, inc, wr ? int'(l) + 1 : 0);
      if (wr) finish_write(int'(l) + 1);
      else read_beats(a, l, st, d0, dl);
    end
    mem_cmp();
    chk("rw_only_busy", bad_rw, 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
